// File: rtl/byte_loader_pkg.sv
// byte_loader_pkg: shared types and constants for the byte_loader slice.
//   state_t        : FSM state encoding (2 bits)
//   DATA_W_DEFAULT : default payload width (matches the 8-bit register stage)
package byte_loader_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      PARITY = 2'd2,
      STOP   = 2'd3
   } state_t;

   localparam int unsigned DATA_W_DEFAULT = 8;

endpackage

// File: rtl/byte_loader_if.sv
// byte_loader_if: serial input and register-load output bundle.
//   sin_vld, sin              : serial stream (master drives)
//   data, enable              : load inputs of the downstream register (slave drives)
//   busy, frame_err           : status (slave drives)
// Modports: master = stream source / register side, slave = byte_loader.
interface byte_loader_if
   import byte_loader_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEFAULT
) ();

   logic              sin_vld;
   logic              sin;
   logic [DATA_W-1:0] data;
   logic              enable;
   logic              busy;
   logic              frame_err;

   modport master (
      output sin_vld, sin,
      input  data, enable, busy, frame_err
   );

   modport slave (
      input  sin_vld, sin,
      output data, enable, busy, frame_err
   );

endinterface

// File: rtl/byte_loader_shreg.sv
// byte_loader_shreg: DATA_W-bit right-shift register (DATA_W >= 2).
//   clk   : clock
//   clr   : synchronous clear (priority over shift)
//   shift : shift enable; din enters at the MSB
//   din   : serial input bit
//   q     : register contents; after DATA_W shifts the first bit is q[0]
module byte_loader_shreg #(
   parameter int unsigned DATA_W = 8
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              shift,
   input  logic              din,
   output logic [DATA_W-1:0] q
);

   always_ff @(posedge clk) begin
      if (clr) begin
         q <= '0;
      end else if (shift) begin
         q <= {din, q[DATA_W-1:1]};
      end
   end

endmodule

// File: rtl/byte_loader.sv
// byte_loader: assembles a framed LSB-first serial stream into a DATA_W-bit
// word and drives the load inputs of the downstream enabled register.
// Frame: start(0) + DATA_W data bits [+ parity bit] + stop(1).
// Optional feature macro: BYTE_LOADER_PARITY_EN (adds a parity bit, sense ODD_PAR).
// Ports:
//   clk  : clock, all logic on posedge
//   rst_ : synchronous active-high reset
//   bus  : byte_loader_if.slave (sin_vld, sin in; data, enable, busy, frame_err out)
// Outputs are all registered; enable/frame_err are single-cycle pulses.
module byte_loader
   import byte_loader_pkg::*;
#(
   parameter int unsigned DATA_W  = DATA_W_DEFAULT,
   parameter bit          ODD_PAR = 1'b0
) (
   input  logic          clk,
   input  logic          rst_,
   byte_loader_if.slave  bus
);

   localparam int unsigned    CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

   state_t             state, state_nxt;
   logic [CNT_W-1:0]   cnt, cnt_nxt;
   logic [DATA_W-1:0]  shreg;
   logic               start;
   logic               shift_en;
   logic               load;
   logic               bad;
   logic               par_bad;
   logic               par_bad_nxt;

   // Start bit clears the shift register so a new frame never sees stale bits.
   byte_loader_shreg #(
      .DATA_W (DATA_W)
   ) u_shreg (
      .clk   (clk),
      .clr   (rst_ | start),
      .shift (shift_en),
      .din   (bus.sin),
      .q     (shreg)
   );

`ifndef BYTE_LOADER_PARITY_EN
   logic unused_odd_par;
   assign unused_odd_par = ODD_PAR;
`endif

   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      start       = 1'b0;
      shift_en    = 1'b0;
      load        = 1'b0;
      bad         = 1'b0;
      par_bad_nxt = par_bad;
      case (state)
         IDLE: begin
            if (bus.sin_vld && !bus.sin) begin
               start       = 1'b1;
               cnt_nxt     = '0;
               par_bad_nxt = 1'b0;
               state_nxt   = SHIFT;
            end
         end
         SHIFT: begin
            if (bus.sin_vld) begin
               shift_en = 1'b1;
               if (cnt == CNT_LAST) begin
                  cnt_nxt = '0;
`ifdef BYTE_LOADER_PARITY_EN
                  state_nxt = PARITY;
`else
                  state_nxt = STOP;
`endif
               end else begin
                  cnt_nxt = cnt + 1'b1;
               end
            end
         end
`ifdef BYTE_LOADER_PARITY_EN
         PARITY: begin
            if (bus.sin_vld) begin
               par_bad_nxt = (bus.sin != (^shreg ^ ODD_PAR));
               state_nxt   = STOP;
            end
         end
`endif
         STOP: begin
            if (bus.sin_vld) begin
               if (bus.sin && !par_bad) begin
                  load = 1'b1;
               end else begin
                  bad = 1'b1;
               end
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst_) begin
         state         <= IDLE;
         cnt           <= '0;
         par_bad       <= 1'b0;
         bus.data      <= '0;
         bus.enable    <= 1'b0;
         bus.frame_err <= 1'b0;
         bus.busy      <= 1'b0;
      end else begin
         state         <= state_nxt;
         cnt           <= cnt_nxt;
         par_bad       <= par_bad_nxt;
         bus.enable    <= load;
         bus.frame_err <= bad;
         // busy registered from the next state so it tracks state != IDLE
         bus.busy      <= (state_nxt != IDLE);
         if (load) begin
            bus.data <= shreg;
         end
      end
   end

endmodule

// File: tb/tb_byte_loader.sv
// tb_byte_loader: randomized + directed scoreboard bench for byte_loader.
// Stimulus pushes the expected outcome of each frame (load/error, word, edge
// index) into a queue; a monitor pops on every enable/frame_err pulse.
// Honours BYTE_LOADER_PARITY_EN the same way as the design.
`timescale 1ns/1ps
module tb_byte_loader;
   import byte_loader_pkg::*;

   localparam int unsigned DATA_W  = DATA_W_DEFAULT;
   localparam bit          ODD_PAR = 1'b0;

   typedef struct {
      bit                is_load;
      logic [DATA_W-1:0] d;
      int unsigned       at_edge;
   } ev_t;

   logic clk = 1'b0;
   logic rst_ = 1'b1;
   byte_loader_if #(.DATA_W(DATA_W)) bif ();

   byte_loader #(
      .DATA_W  (DATA_W),
      .ODD_PAR (ODD_PAR)
   ) dut (
      .clk  (clk),
      .rst_ (rst_),
      .bus  (bif)
   );

   always #5 clk = ~clk;

   int unsigned       cyc = 0;
   int unsigned       vectors = 0;
   int unsigned       miscompares = 0;
   ev_t               sb[$];
   logic [DATA_W-1:0] exp_data = '0;
   bit                frame_busy = 1'b0;
   logic [DATA_W-1:0] reg_q;

   always @(posedge clk) cyc++;

   // downstream enabled register stage
   always @(posedge clk) begin
      if (rst_) reg_q <= '0;
      else if (bif.enable) reg_q <= bif.data;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, cyc);
      end
   endtask

   // monitor: sample 1ns after each rising edge
   initial begin
      ev_t ev;
      forever begin
         @(posedge clk);
         #1;
         if (rst_) begin
            exp_data = '0;
            chk("rst_enable", 32'(bif.enable), 32'd0);
            chk("rst_frame_err", 32'(bif.frame_err), 32'd0);
         end else begin
            if (bif.enable && bif.frame_err)
               chk("enable_and_err", 32'd1, 32'd0);
            if (bif.enable || bif.frame_err) begin
               if (sb.size() == 0) begin
                  chk("unexpected_pulse", 32'(bif.enable), 32'(bif.frame_err & 1'b0));
               end else begin
                  ev = sb.pop_front();
                  chk("pulse_kind", 32'(bif.enable), 32'(ev.is_load));
                  chk("pulse_edge", cyc, ev.at_edge);
                  if (ev.is_load) exp_data = ev.d;
               end
            end
         end
         chk("data", 32'(bif.data), 32'(exp_data));
         chk("busy", 32'(bif.busy), 32'(frame_busy));
      end
   end

   task automatic drive(input logic b);
      bif.sin_vld = 1'b1;
      bif.sin     = b;
      @(negedge clk);
   endtask

   task automatic idle(input int unsigned n);
      bif.sin_vld = 1'b0;
      repeat (n) begin
         bif.sin = 1'($urandom);
         @(negedge clk);
      end
   endtask

   task automatic do_reset(input int unsigned n);
      rst_        = 1'b1;
      bif.sin_vld = 1'b0;
      frame_busy  = 1'b0;
      repeat (n) @(negedge clk);
      rst_ = 1'b0;
   endtask

   // gap_at/abort_at: bit index before which a gap/reset is inserted (-1 = none)
   task automatic send_frame(input logic [DATA_W-1:0] d, input bit stop,
                             input int gap_at, input int unsigned gap_len,
                             input bit par_flip, input int abort_at);
      ev_t ev;
      bit  ok;
      frame_busy = 1'b1;
      drive(1'b0);
      for (int i = 0; i < int'(DATA_W); i++) begin
         if (i == abort_at) begin
            do_reset(2);
            return;
         end
         if (i == gap_at) idle(gap_len);
         drive(d[i]);
      end
      ok = stop;
`ifdef BYTE_LOADER_PARITY_EN
      drive((^d) ^ ODD_PAR ^ par_flip);
      ok = ok && !par_flip;
`else
      ok = ok && (par_flip | 1'b1);
`endif
      ev.is_load = ok;
      ev.d       = d;
      ev.at_edge = cyc + 1;   // stop bit is sampled at the next edge
      sb.push_back(ev);
      frame_busy = 1'b0;
      drive(stop);
      bif.sin_vld = 1'b0;
   endtask

   task automatic drain(input int unsigned max_cyc);
      int unsigned n = 0;
      while (sb.size() != 0 && n < max_cyc) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() != 0) begin
         chk("drain_timeout", sb.size(), 32'd0);
         sb.delete();
      end
   endtask

   initial begin
      bif.sin_vld = 1'b0;
      bif.sin     = 1'b1;
      rst_        = 1'b1;
      repeat (2) @(negedge clk);
      rst_ = 1'b0;
      chk("post_rst_data", 32'(bif.data), 32'd0);
      chk("post_rst_enable", 32'(bif.enable), 32'd0);
      chk("post_rst_busy", 32'(bif.busy), 32'd0);
      chk("post_rst_frame_err", 32'(bif.frame_err), 32'd0);

      idle(2);
      send_frame(8'hAA, 1'b1, -1, 0, 1'b0, -1);
      @(negedge clk);
      chk("reg_q_AA", 32'(reg_q), 32'hAA);

      send_frame(8'h55, 1'b1, 5, 3, 1'b0, -1);
      idle(2);
      send_frame(8'h33, 1'b0, -1, 0, 1'b0, -1);
      idle(2);
      send_frame(8'hC3, 1'b1, -1, 0, 1'b0, 4);
      chk("abort_data", 32'(bif.data), 32'd0);
      send_frame(8'h0F, 1'b1, -1, 0, 1'b0, -1);
      idle(1);
`ifdef BYTE_LOADER_PARITY_EN
      send_frame(8'hAA, 1'b1, -1, 0, 1'b0, -1);
      send_frame(8'hAA, 1'b1, -1, 0, 1'b1, -1);
      idle(1);
`endif
      // back-to-back frames, no idle cycle in between
      send_frame(8'h12, 1'b1, -1, 0, 1'b0, -1);
      send_frame(8'h34, 1'b1, -1, 0, 1'b0, -1);
      drain(40);

      for (int n = 0; n < 60; n++) begin
         logic [DATA_W-1:0] d;
         int                gap_at;
         int                abort_at;
         d        = DATA_W'($urandom);
         gap_at   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, DATA_W - 1)) : -1;
         abort_at = ($urandom_range(0, 14) == 0) ? int'($urandom_range(1, DATA_W - 1)) : -1;
         send_frame(d, ($urandom_range(0, 7) != 0), gap_at, $urandom_range(1, 4),
                    ($urandom_range(0, 7) == 0), abort_at);
         idle($urandom_range(0, 2));
      end
      drain(40);
      repeat (3) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/byte_loader.md
# byte_loader

Serial-to-parallel front end that assembles a framed bit stream into a DATA_W-bit word. It drives the `data`/`enable` load inputs of the downstream 8-bit enabled register stage. For each good frame it presents the word and pulses `enable` for exactly one clock. Bad frames are dropped and flagged, and the register keeps its previous contents.

## Interface
- DATA_W, 8, payload width in bits. The register stage uses 8.
- ODD_PAR, 1'b0, parity sense when parity is compiled in: 0 = even, 1 = odd.

- clk  input  1  system clock; all logic on posedge
- rst_  input  1  synchronous, active-high reset
- sin_vld  input  1  qualifies `sin`; one bit consumed per cycle with `sin_vld`=1
- sin  input  1  serial bit, LSB first
- data  output  DATA_W  assembled word, to register `data`
- enable  output  1  one-cycle load strobe, to register `enable`
- busy  output  1  frame in progress (state != IDLE)
- frame_err  output  1  one-cycle pulse on bad stop bit or bad parity

## Operation
- FSM states: IDLE, SHIFT, PARITY (present only with the macro), STOP.
- IDLE
  - `sin_vld`=1 and `sin`=0 is the start bit: clear the bit counter and go to SHIFT.
  - `sin`=1, or `sin_vld`=0: stay in IDLE.
- SHIFT
  - Each qualified bit shifts into the MSB of the shift register (right shift), so after DATA_W bits the first bit received is bit 0.
  - Counter is $clog2(DATA_W) bits wide, 0..DATA_W-1.
  - After bit DATA_W-1: go to PARITY if compiled in, otherwise to STOP.
- PARITY: one qualified bit is compared with ^shreg ^ ODD_PAR, and the mismatch is recorded. Then go to STOP.
- STOP: one qualified bit.
  - `sin`=1 and no parity mismatch: `data` <= shreg and `enable` <= 1.
  - Otherwise: `frame_err` <= 1, and `data` and `enable` are unchanged.
  - Always return to IDLE.
- `sin_vld`=0 in any state: hold state, counter and shift register. Gaps are unlimited and there is no timeout.
- `data` changes only on a successful STOP. It holds its value between loads.

## Timing
- Reset values: `data`=0, `enable`=0, `busy`=0, `frame_err`=0. State is IDLE, counter 0, shift register 0.
- Reset during a frame aborts it. No `enable` or `frame_err` pulse is produced, and `data` is forced to 0.
- All outputs are registered.
- Latency:
  - Start bit sampled at edge N with no gaps: `enable`=1 during cycle N+DATA_W+2 (N+DATA_W+3 with parity).
  - `enable` and the new `data` become valid in the same cycle. The register captures them at the following edge.
- `enable` and `frame_err` are high for exactly one cycle and are never high together.
- Back-to-back frames: a start bit presented in the cycle where `enable`=1 is accepted, because the FSM is already in IDLE. Consecutive frames need no idle cycle.
- `busy` is 1 from the cycle after the start bit until the cycle after the stop bit.

## Configuration
- BYTE_LOADER_PARITY_EN defined:
  - The PARITY state exists and one parity bit is expected between the last data bit and the stop bit.
  - A mismatch drops the frame and pulses `frame_err`.
- Not defined:
  - No PARITY state and ODD_PAR is ignored.
  - The frame is start + DATA_W data bits + stop.

## Structure
- Package `byte_loader_pkg` holds:
  - the `state_t` enum (IDLE, SHIFT, PARITY, STOP), 2-bit encoding;
  - the constant DATA_W_DEFAULT = 8.
- One sub-module, `byte_loader_shreg`: DATA_W-bit right-shift register with a shift enable and synchronous clear.
- FSM, counter, parity check and output registers live in `byte_loader`.

## Test plan
- Reset: assert `rst_` for 2 cycles -> `data`=8'h00, `enable`=0, `busy`=0, `frame_err`=0.
- Frame 8'hAA sent without gaps (start 0, bits 0,1,0,1,0,1,0,1, stop 1) -> single `enable` pulse with `data`=8'hAA, 10 cycles after start; register output reads 8'hAA.
- Frame 8'h55 with `sin_vld` low for 3 cycles after bit 4 -> `data`=8'h55, `enable` delayed by 3 cycles, `busy` held high through the gap.
- Frame 8'h33 with stop bit 0 -> `frame_err` pulse, no `enable`, `data` keeps the previous 8'h55.
- Reset asserted after bit 3 of a frame, then a clean 8'h0F frame -> no pulse during reset, `data`=0, then 8'h0F loaded.
- With BYTE_LOADER_PARITY_EN and ODD_PAR=0:
  - 8'hAA with parity 0 -> loaded.
  - 8'hAA with parity 1 -> `frame_err`, no `enable`.
  - Back-to-back frames 8'h12, 8'h34 -> two `enable` pulses 11 cycles apart.
